axis_loopback_checker: RTL and testbench

//  Receive-side companion of the 10G loopback traffic generator. Sinks AXI4-Stream frames from one
//  10G MAC RX port, checks header, sequence and deterministic payload sent by the generator on
//  the peer port, and keeps saturating good/bad/sequence-error counters plus a pass flag.
//  One instance per port, between MAC RX and the register block read by the acceptance-test software.

---
 rtl/axis_loopback_checker.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axis_loopback_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_loopback_checker.sv
// -----------------------------------------------------------------------------
// axis_loopback_checker
//
// Receive-side checker for the 10G loopback traffic generator. It sinks
// AXI4-Stream frames from one MAC RX port and checks three things on each
// frame: the header (magic and source port), the deterministic payload
// pattern, and the sequence number. It also keeps saturating statistics and
// a registered pass flag for the acceptance-test register block.
//
// Frame format (64-bit beats, tkeep = 8'hFF on every beat):
//   beat 0      : {MAGIC, port[7:0], rsvd[7:0], seq[31:0]}
//   beat k >= 1 : {~seq, k[31:0]}
//
// Ports
//   axis_aclk      in   clock, rising edge
//   axis_resetn    in   asynchronous active-low reset
//   s_axis_tdata   in   RX data
//   s_axis_tkeep   in   byte enables (must be all ones)
//   s_axis_tuser   in   MAC error flag, checked on every accepted beat
//   s_axis_tvalid  in   beat valid
//   s_axis_tlast   in   last beat of frame
//   s_axis_tready  out  always-ready once out of reset
//   clear_stats    in   single-cycle clear of counters, last_err and seq lock
//   good_cnt       out  frames that passed every check (saturating)
//   bad_cnt        out  frames that failed any content check (saturating)
//   seq_err_cnt    out  sequence discontinuities (saturating)
//   last_err       out  error code of the most recent bad frame
//   link_ok        out  locked, at least one good frame, no bad/seq errors
//
// Error codes: 1 magic, 2 port, 3 payload, 4 length, 5 tkeep, 6 tuser.
// The first error seen in a frame is kept; within one beat the lowest wins.
// -----------------------------------------------------------------------------
module axis_loopback_checker #(
  parameter int          DATA_W    = 64,
  parameter int          CNT_W     = 32,
  parameter int          MIN_BEATS = 8,
  parameter int          MAX_BEATS = 190,
  parameter logic [15:0] MAGIC     = 16'hA55A,
  parameter logic [7:0]  PORT_ID   = 8'h00
) (
  input  logic                axis_aclk,
  input  logic                axis_resetn,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  input  logic                clear_stats,
  output logic [CNT_W-1:0]    good_cnt,
  output logic [CNT_W-1:0]    bad_cnt,
  output logic [CNT_W-1:0]    seq_err_cnt,
  output logic [2:0]          last_err,
  output logic                link_ok
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int BC_W   = $clog2(MAX_BEATS + 1);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_MAGIC   = 3'd1;
  localparam logic [2:0] ERR_PORT    = 3'd2;
  localparam logic [2:0] ERR_PAYLOAD = 3'd3;
  localparam logic [2:0] ERR_LENGTH  = 3'd4;
  localparam logic [2:0] ERR_KEEP    = 3'd5;
  localparam logic [2:0] ERR_USER    = 3'd6;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  // Parser state
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_tready;
  logic [BC_W-1:0]   r_beat_cnt;   // beats accepted so far in this frame
  logic [31:0]       r_seq;
  logic              r_hdr_ok;
  logic [2:0]        r_err_code;   // first error of the frame in flight

  // Frame-end hand-off into the statistics stage
  logic              r_pend_vld;
  logic [2:0]        r_pend_code;
  logic              r_pend_hdr_ok;
  logic [31:0]       r_pend_seq;

  // Statistics
  logic [CNT_W-1:0]  r_good;
  logic [CNT_W-1:0]  r_bad;
  logic [CNT_W-1:0]  r_seq_err;
  logic [2:0]        r_last_err;
  logic              r_locked;
  logic [31:0]       r_exp_seq;
  logic              r_link_ok;

  // Combinational per-beat decode
  logic              w_acc;
  logic              w_magic_ok;
  logic              w_port_ok;
  logic              w_keep_ok;
  logic              w_len_short;
  logic              w_len_long;
  logic [DATA_W-1:0] w_exp_payload;
  logic [2:0]        w_beat_code;
  logic [2:0]        w_frame_code;
  logic              w_frame_end;

  assign w_acc         = s_axis_tvalid & r_tready;
  assign w_frame_end   = w_acc & s_axis_tlast;
  assign w_magic_ok    = (s_axis_tdata[63:48] == MAGIC);
  assign w_port_ok     = (s_axis_tdata[47:40] == PORT_ID);
  assign w_keep_ok     = (s_axis_tkeep == {KEEP_W{1'b1}});
  assign w_exp_payload = {~r_seq, 32'(r_beat_cnt)};
  // The incoming beat's number is r_beat_cnt+1, so the bounds shift by one.
  assign w_len_short   = s_axis_tlast  && (r_beat_cnt < BC_W'(MIN_BEATS - 1));
  assign w_len_long    = !s_axis_tlast && (r_beat_cnt == BC_W'(MAX_BEATS - 1));

  // ---------------------------------------------------------------------------
  // Next state and per-beat error classification
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_beat_code  = ERR_NONE;
    w_frame_code = ERR_NONE;
    unique case (r_state)
      ST_HDR: begin
        if (w_acc) begin
          if (!w_magic_ok)                       w_beat_code = ERR_MAGIC;
          else if (!w_port_ok)                   w_beat_code = ERR_PORT;
          else if (s_axis_tlast && MIN_BEATS > 1) w_beat_code = ERR_LENGTH;
          else if (!w_keep_ok)                   w_beat_code = ERR_KEEP;
          else if (s_axis_tuser)                 w_beat_code = ERR_USER;
          // r_err_code still holds the previous frame here, so ignore it.
          w_frame_code = w_beat_code;
          w_state_nxt  = s_axis_tlast ? ST_HDR : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_acc) begin
          if (s_axis_tdata != w_exp_payload)   w_beat_code = ERR_PAYLOAD;
          else if (w_len_short || w_len_long) w_beat_code = ERR_LENGTH;
          else if (!w_keep_ok)                w_beat_code = ERR_KEEP;
          else if (s_axis_tuser)              w_beat_code = ERR_USER;
          w_frame_code = (r_err_code != ERR_NONE) ? r_err_code : w_beat_code;
          if (s_axis_tlast)    w_state_nxt = ST_HDR;
          else if (w_len_long) w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        // Entry into DROP always recorded an error, so nothing to add here.
        w_frame_code = r_err_code;
        if (w_frame_end) w_state_nxt = ST_HDR;
      end
      default: w_state_nxt = ST_HDR;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame context and frame-end hand-off
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_tready      <= 1'b0;
      r_beat_cnt    <= '0;
      r_seq         <= '0;
      r_hdr_ok      <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_pend_vld    <= 1'b0;
      r_pend_code   <= ERR_NONE;
      r_pend_hdr_ok <= 1'b0;
      r_pend_seq    <= '0;
    end else begin
      r_tready   <= 1'b1;
      r_pend_vld <= w_frame_end;
      if (w_acc) begin
        unique case (r_state)
          ST_HDR: begin
            r_beat_cnt <= BC_W'(1);
            r_seq      <= s_axis_tdata[31:0];
            r_hdr_ok   <= w_magic_ok & w_port_ok;
            r_err_code <= w_beat_code;
          end
          ST_PAYLOAD: begin
            r_beat_cnt <= r_beat_cnt + BC_W'(1);
            r_err_code <= w_frame_code;
          end
          default: ;
        endcase
      end
      if (w_frame_end) begin
        r_pend_code <= w_frame_code;
        // A single-beat frame ends in HDR before its header is latched.
        if (r_state == ST_HDR) begin
          r_pend_hdr_ok <= w_magic_ok & w_port_ok;
          r_pend_seq    <= s_axis_tdata[31:0];
        end else begin
          r_pend_hdr_ok <= r_hdr_ok;
          r_pend_seq    <= r_seq;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics, one cycle after the tlast beat
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_good     <= '0;
      r_bad      <= '0;
      r_seq_err  <= '0;
      r_last_err <= ERR_NONE;
      r_locked   <= 1'b0;
      r_exp_seq  <= '0;
      r_link_ok  <= 1'b0;
    end else begin
      r_link_ok <= r_locked && (r_good != '0) && (r_bad == '0) && (r_seq_err == '0);
      if (clear_stats) begin
        // Clear takes priority: a frame-end update on this edge is dropped.
        r_good     <= '0;
        r_bad      <= '0;
        r_seq_err  <= '0;
        r_last_err <= ERR_NONE;
        r_locked   <= 1'b0;
      end else if (r_pend_vld) begin
        if (r_pend_code != ERR_NONE) begin
          r_bad      <= sat_inc(r_bad);
          r_last_err <= r_pend_code;
        end else begin
          r_good <= sat_inc(r_good);
        end
        // Sequence tracking follows any frame with a valid header, good
        // payload or not; a mismatch is counted but does not fail the frame.
        if (r_pend_hdr_ok) begin
          if (r_locked && (r_pend_seq != r_exp_seq)) r_seq_err <= sat_inc(r_seq_err);
          r_locked  <= 1'b1;
          r_exp_seq <= r_pend_seq + 32'd1;
        end
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign good_cnt      = r_good;
  assign bad_cnt       = r_bad;
  assign seq_err_cnt   = r_seq_err;
  assign last_err      = r_last_err;
  assign link_ok       = r_link_ok;

endmodule

// File: tb/tb_axis_loopback_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_loopback_checker
//
// Directed bench for axis_loopback_checker. Two instances share all inputs:
// u_dut with 32-bit counters and u_sat with 4-bit counters for saturation.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_loopback_checker;

  localparam logic [15:0] MAGIC = 16'hA55A;

  logic        clk;
  logic        rst_n;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tuser;
  logic        tvalid;
  logic        tlast;
  logic        clear;

  logic        tready;
  logic [31:0] good_cnt, bad_cnt, seq_err_cnt;
  logic [2:0]  last_err;
  logic        link_ok;

  logic        s_tready;
  logic [3:0]  s_good, s_bad, s_seq_err;
  logic [2:0]  s_last_err;
  logic        s_link_ok;

  int n_total = 0;
  int n_bad   = 0;

  axis_loopback_checker u_dut (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tuser  (tuser),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (tready),
    .clear_stats   (clear),
    .good_cnt      (good_cnt),
    .bad_cnt       (bad_cnt),
    .seq_err_cnt   (seq_err_cnt),
    .last_err      (last_err),
    .link_ok       (link_ok)
  );

  axis_loopback_checker #(.CNT_W(4)) u_sat (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tuser  (tuser),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (s_tready),
    .clear_stats   (clear),
    .good_cnt      (s_good),
    .bad_cnt       (s_bad),
    .seq_err_cnt   (s_seq_err),
    .last_err      (s_last_err),
    .link_ok       (s_link_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame, driven back to back. Index -1 disables a fault.
  task automatic send_frame(input logic [31:0] seq, input int nbeats,
                            input logic [15:0] magic, input logic [7:0] port,
                            input int bad_beat, input int keep_beat, input int user_beat);
    for (int k = 0; k < nbeats; k++) begin
      if (k == 0) tdata = {magic, port, 8'h00, seq};
      else        tdata = {~seq, 32'(k)};
      if (k == bad_beat) tdata = tdata ^ 64'd1;
      tkeep  = (k == keep_beat) ? 8'h0F : 8'hFF;
      tuser  = (k == user_beat);
      tvalid = 1'b1;
      tlast  = (k == nbeats - 1);
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic good_frame(input logic [31:0] seq);
    send_frame(seq, 8, MAGIC, 8'h00, -1, -1, -1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tdata = '0; tkeep = 8'hFF; tuser = 1'b0;
    tvalid = 1'b0; tlast = 1'b0; clear = 1'b0;

    // Power-on reset
    idle(3);
    check("por_tready", tready, 0);
    check("por_good", good_cnt, 0);
    check("por_link", link_ok, 0);
    rst_n = 1'b1;
    #1;
    check("rel_tready_before_edge", tready, 0);
    @(negedge clk);
    check("rel_tready_after_edge", tready, 1);

    // Three good frames, seq 0,1,2
    good_frame(32'd0);
    good_frame(32'd1);
    good_frame(32'd2);
    idle(3);
    check("t2_good", good_cnt, 3);
    check("t2_bad", bad_cnt, 0);
    check("t2_seq_err", seq_err_cnt, 0);
    check("t2_last_err", last_err, 0);
    check("t2_link", link_ok, 1);

    // Reset asserted in the middle of a frame
    send_frame(32'd100, 4, MAGIC, 8'h00, -1, -1, -1);
    tvalid = 1'b1; tlast = 1'b0; tdata = {~32'd100, 32'd4};
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tready", tready, 0);
    check("mid_rst_good", good_cnt, 0);
    check("mid_rst_link", link_ok, 0);
    tvalid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    #1;
    check("mid_rel_tready_before_edge", tready, 0);
    @(negedge clk);
    check("mid_rel_tready", tready, 1);

    // First beat after reset is a header; then a payload-corrupted frame
    good_frame(32'd7);
    send_frame(32'd8, 8, MAGIC, 8'h00, 3, -1, -1);
    idle(3);
    check("t3_good", good_cnt, 1);
    check("t3_bad", bad_cnt, 1);
    check("t3_last_err", last_err, 3);
    check("t3_seq_err", seq_err_cnt, 0);
    check("t3_link", link_ok, 0);

    pulse_clear();
    idle(2);
    check("clr_bad", bad_cnt, 0);
    check("clr_last_err", last_err, 0);

    // Sequence gap 0,1,5,6
    good_frame(32'd0);
    good_frame(32'd1);
    good_frame(32'd5);
    good_frame(32'd6);
    idle(3);
    check("t4_good", good_cnt, 4);
    check("t4_seq_err", seq_err_cnt, 1);
    check("t4_link", link_ok, 0);

    // Sequence wrap FFFFFFFF -> 0
    pulse_clear();
    good_frame(32'hFFFF_FFFF);
    good_frame(32'd0);
    idle(3);
    check("wrap_seq_err", seq_err_cnt, 0);
    check("wrap_good", good_cnt, 2);
    check("wrap_link", link_ok, 1);

    // Length and error-code cases
    pulse_clear();
    send_frame(32'd10, 192, MAGIC, 8'h00, -1, -1, -1);
    good_frame(32'd11);
    idle(3);
    check("long_bad", bad_cnt, 1);
    check("long_last_err", last_err, 4);
    check("long_then_good", good_cnt, 1);
    send_frame(32'd12, 190, MAGIC, 8'h00, -1, -1, -1);
    idle(3);
    check("max_len_good", good_cnt, 2);
    send_frame(32'd13, 4, MAGIC, 8'h00, -1, -1, -1);
    idle(3);
    check("short4_bad", bad_cnt, 2);
    check("short4_last_err", last_err, 4);
    send_frame(32'd14, 7, MAGIC, 8'h00, -1, -1, -1);
    idle(3);
    check("short7_bad", bad_cnt, 3);
    send_frame(32'd15, 8, 16'h1234, 8'h00, -1, -1, -1);
    idle(3);
    check("magic_code", last_err, 1);
    send_frame(32'd15, 8, MAGIC, 8'h01, -1, -1, -1);
    idle(3);
    check("port_code", last_err, 2);
    send_frame(32'd15, 8, MAGIC, 8'h00, -1, 4, -1);
    idle(3);
    check("keep_code", last_err, 5);
    send_frame(32'd16, 8, MAGIC, 8'h00, -1, -1, 7);
    idle(3);
    check("user_code", last_err, 6);
    send_frame(32'd17, 8, MAGIC, 8'h00, 5, -1, 5);
    idle(3);
    check("payload_beats_user", last_err, 3);
    check("t5_bad_total", bad_cnt, 8);
    check("t5_good_total", good_cnt, 2);
    check("t5_seq_err", seq_err_cnt, 0);

    // Clear on the same edge as a frame-end update
    good_frame(32'd18);
    pulse_clear();
    idle(2);
    check("coinc_good", good_cnt, 0);
    check("coinc_bad", bad_cnt, 0);
    check("coinc_last_err", last_err, 0);
    check("coinc_link", link_ok, 0);
    good_frame(32'd50);
    idle(3);
    check("coinc_unlocked_seq_err", seq_err_cnt, 0);
    check("coinc_next_good", good_cnt, 1);
    check("coinc_next_link", link_ok, 1);

    // Saturation of 4-bit counters
    pulse_clear();
    for (int i = 0; i < 20; i++) good_frame(32'(i));
    idle(3);
    check("sat_good_4bit", s_good, 15);
    check("wide_good", good_cnt, 20);
    check("sat_link", s_link_ok, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
